// File: rtl/fetch_pkg.sv
// Shared definitions for the IF-stage PC generator: default widths, 2-bit
// branch-counter encoding and small helpers for counter and field sizing.
package fetch_pkg;

   localparam int unsigned PC_W_DEFAULT = 12;

   typedef enum logic [1:0] {
      SNT = 2'b00,
      WNT = 2'b01,
      WT  = 2'b10,
      ST  = 2'b11
   } ctr_t;

   // Saturating increment of a 2-bit predictor counter
   function automatic ctr_t ctr_inc(input ctr_t c);
      return (c == ST) ? ST : ctr_t'(c + 2'b01);
   endfunction

   // Saturating decrement of a 2-bit predictor counter
   function automatic ctr_t ctr_dec(input ctr_t c);
      return (c == SNT) ? SNT : ctr_t'(c - 2'b01);
   endfunction

   // Tag width left over once the word offset and the index are removed
   function automatic int unsigned tag_width(input int unsigned pc_w, input int unsigned idx_w);
      return pc_w - 2 - idx_w;
   endfunction

endpackage

// File: rtl/btb_bank.sv
// Direct-mapped BTB storage: two combinational read ports (fetch lookup and
// EX training lookup), one synchronous write port, asynchronous clear.
module btb_bank
   import fetch_pkg::*;
#(
   parameter int unsigned ENTRIES = 16,
   parameter int unsigned IDX_W   = 4,
   parameter int unsigned TAG_W   = 6,
   parameter int unsigned PC_W    = 12
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [IDX_W-1:0] f_idx,
   output logic             f_valid,
   output logic [TAG_W-1:0] f_tag,
   output ctr_t             f_ctr,
   output logic [PC_W-1:0]  f_target,
   input  logic [IDX_W-1:0] u_idx,
   output logic             u_valid,
   output logic [TAG_W-1:0] u_tag,
   output ctr_t             u_ctr,
   output logic [PC_W-1:0]  u_target,
   input  logic             wr_en,
   input  logic [IDX_W-1:0] wr_idx,
   input  logic [TAG_W-1:0] wr_tag,
   input  ctr_t             wr_ctr,
   input  logic [PC_W-1:0]  wr_target
);

   logic             valid_q  [ENTRIES];
   logic [TAG_W-1:0] tag_q    [ENTRIES];
   ctr_t             ctr_q    [ENTRIES];
   logic [PC_W-1:0]  target_q [ENTRIES];

   // Entry storage: cleared asynchronously, one entry written per cycle
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         for (int unsigned i = 0; i < ENTRIES; i++) begin
            valid_q[i]  <= 1'b0;
            tag_q[i]    <= '0;
            ctr_q[i]    <= WNT;
            target_q[i] <= '0;
         end
      end else if (wr_en) begin
         valid_q[wr_idx]  <= 1'b1;
         tag_q[wr_idx]    <= wr_tag;
         ctr_q[wr_idx]    <= wr_ctr;
         target_q[wr_idx] <= wr_target;
      end
   end

   // Read ports see pre-write contents; a write shows up the next cycle
   always_comb begin
      f_valid  = valid_q[f_idx];
      f_tag    = tag_q[f_idx];
      f_ctr    = ctr_q[f_idx];
      f_target = target_q[f_idx];
      u_valid  = valid_q[u_idx];
      u_tag    = tag_q[u_idx];
      u_ctr    = ctr_q[u_idx];
      u_target = target_q[u_idx];
   end

endmodule

// File: rtl/fetch_pc_unit.sv
// IF-stage PC generator: PC register, next-PC selection (redirect, stall,
// BTB prediction, sequential) and BTB training from EX-resolved transfers.
module fetch_pc_unit
   import fetch_pkg::*;
#(
   parameter int unsigned     PC_W        = PC_W_DEFAULT,
   parameter int unsigned     BTB_ENTRIES = 16,
   parameter logic [PC_W-1:0] RESET_PC    = '0
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            riscv_start,
   input  logic            riscv_done,
   input  logic            icache_stall,
   input  logic            dcache_stall,
   input  logic            md_alu_stall,
   input  logic            load_use_stall,
   input  logic            ex_redirect,
   input  logic [PC_W-1:0] ex_redirect_pc,
   input  logic            ex_update,
   input  logic [PC_W-1:0] ex_pc,
   input  logic            ex_taken,
   input  logic [PC_W-1:0] ex_target,
   output logic [PC_W-1:0] pc_out,
   output logic [PC_W-1:0] pc_plus_4,
   output logic            predict_taken,
   output logic            btb_hit
);

   localparam int unsigned IDX_W = $clog2(BTB_ENTRIES);
   localparam int unsigned TAG_W = tag_width(PC_W, IDX_W);

   logic [PC_W-1:0]  pc_q;
   logic [PC_W-1:0]  pc_next;
   logic             run;
   logic             stall_any;

   logic [IDX_W-1:0] f_idx;
   logic [TAG_W-1:0] f_tag;
   logic             f_valid;
   logic [TAG_W-1:0] f_tag_rd;
   ctr_t             f_ctr;
   logic [PC_W-1:0]  f_target;

   logic [IDX_W-1:0] u_idx;
   logic [TAG_W-1:0] u_tag;
   logic             u_valid;
   logic [TAG_W-1:0] u_tag_rd;
   ctr_t             u_ctr;
   logic [PC_W-1:0]  u_target;
   logic             u_hit;

   logic             wr_en;
   ctr_t             wr_ctr;
   logic [PC_W-1:0]  wr_target;

   logic             unused_bits;

   assign run       = riscv_start && !riscv_done;
   assign stall_any = icache_stall || dcache_stall || md_alu_stall || load_use_stall;

   assign f_idx = pc_q[IDX_W+1:2];
   assign f_tag = pc_q[PC_W-1:IDX_W+2];
   assign u_idx = ex_pc[IDX_W+1:2];
   assign u_tag = ex_pc[PC_W-1:IDX_W+2];

   assign pc_out        = pc_q;
   assign pc_plus_4     = pc_q + PC_W'(4);
   assign btb_hit       = f_valid && (f_tag_rd == f_tag);
   assign predict_taken = btb_hit && f_ctr[1];
   assign u_hit         = u_valid && (u_tag_rd == u_tag);

   // Word-offset bits carry no information for fetch or indexing
   assign unused_bits = ^{ex_pc[1:0], pc_next[1:0]};

   btb_bank #(
      .ENTRIES (BTB_ENTRIES),
      .IDX_W   (IDX_W),
      .TAG_W   (TAG_W),
      .PC_W    (PC_W)
   ) u_btb (
      .clk       (clk),
      .reset     (reset),
      .f_idx     (f_idx),
      .f_valid   (f_valid),
      .f_tag     (f_tag_rd),
      .f_ctr     (f_ctr),
      .f_target  (f_target),
      .u_idx     (u_idx),
      .u_valid   (u_valid),
      .u_tag     (u_tag_rd),
      .u_ctr     (u_ctr),
      .u_target  (u_target),
      .wr_en     (wr_en),
      .wr_idx    (u_idx),
      .wr_tag    (u_tag),
      .wr_ctr    (wr_ctr),
      .wr_target (wr_target)
   );

   // Next-PC priority: redirect beats stalls, stalls beat prediction
   always_comb begin
      pc_next = pc_q;
      if (run) begin
         if (ex_redirect)        pc_next = ex_redirect_pc;
         else if (stall_any)     pc_next = pc_q;
         else if (predict_taken) pc_next = f_target;
         else                    pc_next = pc_plus_4;
      end
   end

   // PC register; fetch addresses are kept word aligned
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) pc_q <= RESET_PC;
      else        pc_q <= {pc_next[PC_W-1:2], 2'b00};
   end

   // Training decode: update on hit, allocate only on a taken miss
   always_comb begin
      wr_en     = 1'b0;
      wr_ctr    = u_ctr;
      wr_target = u_target;
      if (run && ex_update) begin
         if (u_hit) begin
            wr_en = 1'b1;
            if (ex_taken) begin
               wr_ctr    = ctr_inc(u_ctr);
               wr_target = ex_target;
            end else begin
               wr_ctr    = ctr_dec(u_ctr);
            end
         end else if (ex_taken) begin
            wr_en     = 1'b1;
            wr_ctr    = WT;
            wr_target = ex_target;
         end
      end
   end

endmodule

// File: tb/tb_fetch_pc_unit.sv
// Self-checking bench for fetch_pc_unit: directed scenarios followed by
// randomized traffic, all checked against an array-based reference model.
module tb_fetch_pc_unit;

   logic        clk = 1'b0;
   logic        reset;
   logic        riscv_start, riscv_done;
   logic        icache_stall, dcache_stall, md_alu_stall, load_use_stall;
   logic        ex_redirect;
   logic [11:0] ex_redirect_pc;
   logic        ex_update;
   logic [11:0] ex_pc;
   logic        ex_taken;
   logic [11:0] ex_target;
   logic [11:0] pc_out, pc_plus_4;
   logic        predict_taken, btb_hit;

   int checks = 0;
   int errors = 0;

   // Reference model: PC plus a 16-entry direct-mapped table
   int m_pc;
   bit m_v   [16];
   int m_tag [16];
   int m_tgt [16];
   int m_ctr [16];

   always #5 clk = ~clk;

   fetch_pc_unit #(.PC_W(12), .BTB_ENTRIES(16), .RESET_PC(12'h000)) dut (
      .clk            (clk),
      .reset          (reset),
      .riscv_start    (riscv_start),
      .riscv_done     (riscv_done),
      .icache_stall   (icache_stall),
      .dcache_stall   (dcache_stall),
      .md_alu_stall   (md_alu_stall),
      .load_use_stall (load_use_stall),
      .ex_redirect    (ex_redirect),
      .ex_redirect_pc (ex_redirect_pc),
      .ex_update      (ex_update),
      .ex_pc          (ex_pc),
      .ex_taken       (ex_taken),
      .ex_target      (ex_target),
      .pc_out         (pc_out),
      .pc_plus_4      (pc_plus_4),
      .predict_taken  (predict_taken),
      .btb_hit        (btb_hit)
   );

   function automatic int m_idx(input int pc);
      return (pc / 4) % 16;
   endfunction

   function automatic int m_tagof(input int pc);
      return pc / 64;
   endfunction

   function bit m_hit();
      return m_v[m_idx(m_pc)] && (m_tag[m_idx(m_pc)] == m_tagof(m_pc));
   endfunction

   function bit m_pred();
      return m_hit() && (m_ctr[m_idx(m_pc)] >= 2);
   endfunction

   function void model_reset();
      m_pc = 0;
      for (int i = 0; i < 16; i++) begin
         m_v[i] = 0; m_tag[i] = 0; m_tgt[i] = 0; m_ctr[i] = 1;
      end
   endfunction

   function automatic int pick_pc();
      int r;
      r = int'($urandom_range(0, 31));
      if (r == 0) return 'hFFC;
      return (int'($urandom_range(0, 31)) * 4) + (($urandom_range(0, 1) == 1) ? 'h400 : 0);
   endfunction

   task automatic check(input string name, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", name, obs, exp);
      end
   endtask

   task automatic check_outputs();
      check("pc_out",        {20'b0, pc_out},        32'(m_pc));
      check("pc_plus_4",     {20'b0, pc_plus_4},     32'((m_pc + 4) % 4096));
      check("btb_hit",       {31'b0, btb_hit},       {31'b0, m_hit()});
      check("predict_taken", {31'b0, predict_taken}, {31'b0, m_pred()});
   endtask

   // One cycle: check current outputs, advance model with current inputs, clock
   task automatic tick();
      int nxt, i, j;
      bit run, eh;
      check_outputs();
      run = riscv_start && !riscv_done;
      i   = m_idx(m_pc);
      nxt = m_pc;
      if (run) begin
         if (ex_redirect)
            nxt = int'(ex_redirect_pc);
         else if (icache_stall || dcache_stall || md_alu_stall || load_use_stall)
            nxt = m_pc;
         else if (m_pred())
            nxt = m_tgt[i];
         else
            nxt = (m_pc + 4) % 4096;
      end
      if (run && ex_update) begin
         j  = m_idx(int'(ex_pc));
         eh = m_v[j] && (m_tag[j] == m_tagof(int'(ex_pc)));
         if (eh && ex_taken) begin
            m_ctr[j] = (m_ctr[j] < 3) ? m_ctr[j] + 1 : 3;
            m_tgt[j] = int'(ex_target);
         end else if (eh) begin
            m_ctr[j] = (m_ctr[j] > 0) ? m_ctr[j] - 1 : 0;
         end else if (ex_taken) begin
            m_v[j] = 1; m_tag[j] = m_tagof(int'(ex_pc));
            m_tgt[j] = int'(ex_target); m_ctr[j] = 2;
         end
      end
      m_pc = nxt & 'hFFC;
      @(posedge clk);
      #1;
   endtask

   task automatic redirect_to(input logic [11:0] pc);
      ex_redirect = 1'b1; ex_redirect_pc = pc;
      tick();
      ex_redirect = 1'b0;
   endtask

   initial begin
      reset = 1'b0; riscv_start = 1'b0; riscv_done = 1'b0;
      icache_stall = 1'b0; dcache_stall = 1'b0; md_alu_stall = 1'b0; load_use_stall = 1'b0;
      ex_redirect = 1'b0; ex_redirect_pc = '0; ex_update = 1'b0;
      ex_pc = '0; ex_taken = 1'b0; ex_target = '0;
      model_reset();
      #1;
      check("rst_pc", {20'b0, pc_out}, 32'h000);
      check("rst_pc4", {20'b0, pc_plus_4}, 32'h004);
      check("rst_hit", {31'b0, btb_hit}, 32'h0);
      check("rst_pred", {31'b0, predict_taken}, 32'h0);
      @(posedge clk); #1;
      reset = 1'b1; riscv_start = 1'b1;

      // Sequential fetch from reset
      tick(); tick();
      check("seq_pc", {20'b0, pc_out}, 32'h008);

      // Allocate taken branch at 0x010 -> 0x100
      ex_update = 1'b1; ex_pc = 12'h010; ex_taken = 1'b1; ex_target = 12'h100;
      tick();
      ex_update = 1'b0;
      tick();
      check("alloc_hit", {31'b0, btb_hit}, 32'h1);
      check("alloc_pred", {31'b0, predict_taken}, 32'h1);
      tick();
      check("alloc_tgt", {20'b0, pc_out}, 32'h100);

      // Two not-taken updates: 10 -> 01 -> 00
      ex_update = 1'b1; ex_taken = 1'b0;
      tick(); tick();
      ex_update = 1'b0;
      redirect_to(12'h010);
      check("nt_hit", {31'b0, btb_hit}, 32'h1);
      check("nt_pred", {31'b0, predict_taken}, 32'h0);
      tick();
      check("nt_next", {20'b0, pc_out}, 32'h014);

      // Redirect wins over stall; stall alone holds
      icache_stall = 1'b1;
      redirect_to(12'h200);
      check("redir_stall", {20'b0, pc_out}, 32'h200);
      tick();
      check("stall_hold", {20'b0, pc_out}, 32'h200);
      icache_stall = 1'b0;
      tick();
      check("stall_release", {20'b0, pc_out}, 32'h204);

      // Aliasing at index 4
      redirect_to(12'h410);
      check("alias_miss", {31'b0, btb_hit}, 32'h0);
      ex_update = 1'b1; ex_pc = 12'h410; ex_taken = 1'b1; ex_target = 12'h080;
      tick();
      ex_update = 1'b0;
      redirect_to(12'h010);
      check("evicted", {31'b0, btb_hit}, 32'h0);
      redirect_to(12'h410);
      check("alias_hit", {31'b0, btb_hit}, 32'h1);
      tick();
      check("alias_tgt", {20'b0, pc_out}, 32'h080);

      // Done freezes PC and BTB
      riscv_done = 1'b1; ex_redirect = 1'b1; ex_redirect_pc = 12'h300;
      ex_update = 1'b1; ex_pc = 12'h300; ex_taken = 1'b1; ex_target = 12'h040;
      tick(); tick();
      check("done_hold", {20'b0, pc_out}, 32'h080);
      riscv_done = 1'b0; ex_redirect = 1'b0; ex_update = 1'b0;
      redirect_to(12'h300);
      check("done_no_train", {31'b0, btb_hit}, 32'h0);

      // Wrap at top of PC space
      redirect_to(12'hFFC);
      check("wrap_pc4", {20'b0, pc_plus_4}, 32'h000);
      tick();
      check("wrap_pc", {20'b0, pc_out}, 32'h000);

      // Asynchronous reset during a stall
      icache_stall = 1'b1;
      redirect_to(12'h410);
      tick();
      reset = 1'b0;
      #1;
      model_reset();
      check("async_pc", {20'b0, pc_out}, 32'h000);
      check("async_hit", {31'b0, btb_hit}, 32'h0);
      reset = 1'b1; icache_stall = 1'b0;
      redirect_to(12'h410);
      check("cleared_entry", {31'b0, btb_hit}, 32'h0);

      // Randomized traffic
      for (int n = 0; n < 600; n++) begin
         riscv_done     = ($urandom_range(0, 19) == 0);
         icache_stall   = ($urandom_range(0, 9) == 0);
         dcache_stall   = ($urandom_range(0, 15) == 0);
         md_alu_stall   = ($urandom_range(0, 15) == 0);
         load_use_stall = ($urandom_range(0, 15) == 0);
         ex_redirect    = ($urandom_range(0, 7) == 0);
         ex_redirect_pc = 12'(pick_pc());
         ex_update      = ($urandom_range(0, 2) == 0);
         ex_pc          = 12'(pick_pc());
         ex_taken       = ($urandom_range(0, 1) == 1);
         ex_target      = 12'(pick_pc());
         tick();
      end
      check_outputs();

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
